// File: rtl/fifo_word_serializer_if.sv
// Handshake bundle between the serializer, its upstream FIFO read port and its downstream write port.
// Latency: none (wires only).
// Backpressure: in_empty/out_full carry upstream-empty and downstream-full; in_read_en is the pop strobe.
interface fifo_word_serializer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_empty;
    logic                 in_read_en;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_write_en;
    logic                 out_full;
    logic                 busy;

    // Serializer side: pops the upstream FIFO and writes the downstream one.
    modport master (
        input  in_data,
        input  in_empty,
        output in_read_en,
        output out_data,
        output out_write_en,
        input  out_full,
        output busy
    );

    // Environment side: upstream FIFO head, downstream full flag, status observer.
    modport slave (
        output in_data,
        output in_empty,
        input  in_read_en,
        input  out_data,
        input  out_write_en,
        output out_full,
        input  busy
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Splits each popped IN_WIDTH word into RATIO OUT_WIDTH segments, one per clock, with no gaps between words.
// Latency: first segment valid one cycle after the pop; a word takes exactly RATIO cycles when unthrottled.
// Backpressure: out_full freezes segment, count and shift register; the next word is popped only on the last-segment transfer.
module fifo_word_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_word_serializer_if.master bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
    end

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       seg_cnt_q;
    logic [IN_WIDTH-1:0] shift_q;

    logic last_seg;
    logic pop;

    assign last_seg = (seg_cnt_q == CW'(RATIO - 1));

    // Ready for a new word when idle, or when the final segment leaves this cycle.
    assign bus.in_read_en = (state_q == ST_IDLE) | (last_seg & ~bus.out_full);
    assign pop            = bus.in_read_en & ~bus.in_empty;

    // The shift register is cleared whenever the block goes idle, so the
    // presented segment is already zero whenever out_write_en is low.
    assign bus.out_data     = MSB_FIRST ? shift_q[IN_WIDTH-1 -: OUT_WIDTH] : shift_q[OUT_WIDTH-1:0];
    assign bus.out_write_en = (state_q == ST_SHIFT);
    assign bus.busy         = (state_q == ST_SHIFT);

    // Word load, segment shifting and idle/shift sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seg_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q   <= bus.in_data;
                        seg_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!bus.out_full) begin
                        if (!last_seg) begin
                            shift_q   <= MSB_FIRST ? (shift_q << OUT_WIDTH) : (shift_q >> OUT_WIDTH);
                            seg_cnt_q <= seg_cnt_q + CW'(1);
                        end else if (pop) begin
                            // Back-to-back: next word replaces the one just finished.
                            shift_q   <= bus.in_data;
                            seg_cnt_q <= '0;
                        end else begin
                            shift_q   <= '0;
                            seg_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    seg_cnt_q <= '0;
                    shift_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_word_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) ifm ();
    fifo_word_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) ifl ();

    // The LSB-first instance sees exactly the same stimulus as the MSB-first one.
    assign ifl.in_data  = ifm.in_data;
    assign ifl.in_empty = ifm.in_empty;
    assign ifl.out_full = ifm.out_full;

    fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bus(ifm)
    );
    fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bus(ifl)
    );

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [7:0]  s1m [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0]  s1l [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic [7:0]  s2m [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0]  s2l [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    logic [7:0]  s3m [7] = '{8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0]  s3l [7] = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hA1};
    logic [7:0]  s4m [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    logic [7:0]  s4l [4] = '{8'h8D, 8'h7C, 8'h6B, 8'h5A};
    logic [31:0] words [1000];
    logic [7:0]  q_m [$];
    logic [7:0]  q_l [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at the falling edge: counts a pop that the next rising edge will take, then moves past that edge.
    task automatic adv();
        if (ifm.in_read_en === 1'b1 && ifm.in_empty === 1'b0) pops++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wen_m"},  32'(ifm.out_write_en), 32'd0);
        chk({tag, "_busy_m"}, 32'(ifm.busy),         32'd0);
        chk({tag, "_data_m"}, 32'(ifm.out_data),     32'd0);
        chk({tag, "_wen_l"},  32'(ifl.out_write_en), 32'd0);
        chk({tag, "_data_l"}, 32'(ifl.out_data),     32'd0);
    endtask

    initial begin
        int cycles;
        int recv;
        int idx;
        int seg_idx;
        logic pop_now;
        logic xfer_now;
        logic [7:0] e_m;
        logic [7:0] e_l;

        rst          = 1'b1;
        ifm.in_data  = '0;
        ifm.in_empty = 1'b1;
        ifm.out_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk_idle("reset");
        chk("reset_rdy", 32'(ifm.in_read_en), 32'd1);
        adv();

        // Single word, both segment orders
        pops = 0;
        ifm.in_data  = 32'hA1B2C3D4;
        ifm.in_empty = 1'b0;
        @(negedge clk);
        chk("single_pop_rdy", 32'(ifm.in_read_en), 32'd1);
        adv();
        ifm.in_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_seg_m", 32'(ifm.out_data), 32'(s1m[i]));
            chk("single_seg_l", 32'(ifl.out_data), 32'(s1l[i]));
            chk("single_wen",   32'(ifm.out_write_en), 32'd1);
            chk("single_rdy",   32'(ifm.in_read_en), (i == 3) ? 32'd1 : 32'd0);
            adv();
        end
        @(negedge clk);
        chk_idle("single_end");
        chk("single_pops", 32'(pops), 32'd1);
        adv();

        // Back-to-back words, FIFO never empty
        pops = 0;
        ifm.in_data  = 32'h11223344;
        ifm.in_empty = 1'b0;
        @(negedge clk);
        adv();
        ifm.in_data = 32'h55667788;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) ifm.in_empty = 1'b1;
            @(negedge clk);
            chk("b2b_seg_m", 32'(ifm.out_data), 32'(s2m[i]));
            chk("b2b_seg_l", 32'(ifl.out_data), 32'(s2l[i]));
            chk("b2b_wen",   32'(ifm.out_write_en), 32'd1);
            if (i == 3) chk("b2b_second_pop", 32'(ifm.in_read_en & ~ifm.in_empty), 32'd1);
            adv();
        end
        @(negedge clk);
        chk_idle("b2b_end");
        chk("b2b_pops", 32'(pops), 32'd2);
        adv();

        // Downstream full for 3 cycles on the second segment
        pops = 0;
        ifm.in_data  = 32'hA1B2C3D4;
        ifm.in_empty = 1'b0;
        @(negedge clk);
        adv();
        for (int i = 0; i < 7; i++) begin
            ifm.in_empty = 1'b1;
            ifm.out_full = (i >= 1 && i <= 3);
            if (i == 2) ifm.in_empty = 1'b0;
            @(negedge clk);
            chk("stall_seg_m", 32'(ifm.out_data), 32'(s3m[i]));
            chk("stall_seg_l", 32'(ifl.out_data), 32'(s3l[i]));
            chk("stall_wen",   32'(ifm.out_write_en), 32'd1);
            if (i >= 1 && i <= 3) chk("stall_rdy", 32'(ifm.in_read_en), 32'd0);
            adv();
        end
        ifm.in_empty = 1'b1;
        ifm.out_full = 1'b0;
        @(negedge clk);
        chk_idle("stall_end");
        chk("stall_pops", 32'(pops), 32'd1);
        adv();

        // Reset in the middle of a word
        ifm.in_data  = 32'hA1B2C3D4;
        ifm.in_empty = 1'b0;
        @(negedge clk);
        adv();
        ifm.in_empty = 1'b1;
        @(negedge clk);
        chk("rst_first_m", 32'(ifm.out_data), 32'hA1);
        adv();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pending_m", 32'(ifm.out_data), 32'hB2);
        adv();
        rst          = 1'b0;
        ifm.in_data  = 32'h5A6B7C8D;
        ifm.in_empty = 1'b0;
        @(negedge clk);
        chk_idle("rst_after");
        adv();
        ifm.in_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_next_m", 32'(ifm.out_data), 32'(s4m[i]));
            chk("rst_next_l", 32'(ifl.out_data), 32'(s4l[i]));
            adv();
        end
        @(negedge clk);
        chk_idle("rst_next_end");
        adv();

        // Random throttling on both sides against a scoreboard
        for (int i = 0; i < 1000; i++) words[i] = $urandom;
        cycles  = 0;
        recv    = 0;
        idx     = 0;
        seg_idx = 0;
        while (recv < 4000 && cycles < 40000) begin
            ifm.in_empty = (idx >= 1000) ? 1'b1 : ($urandom_range(0, 9) < 3);
            ifm.in_data  = (idx < 1000) ? words[idx] : 32'd0;
            ifm.out_full = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            pop_now  = ifm.in_read_en & ~ifm.in_empty;
            xfer_now = ifm.out_write_en & ~ifm.out_full;
            if (pop_now && ifm.busy) chk("rand_pop_while_busy", 32'(xfer_now && seg_idx == 3), 32'd1);
            if (xfer_now) begin
                e_m = (q_m.size() > 0) ? q_m.pop_front() : 8'hxx;
                e_l = (q_l.size() > 0) ? q_l.pop_front() : 8'hxx;
                chk("rand_seg_m", 32'(ifm.out_data), 32'(e_m));
                chk("rand_seg_l", 32'(ifl.out_data), 32'(e_l));
                seg_idx = (seg_idx + 1) % 4;
                recv++;
            end
            if (pop_now) begin
                for (int k = 3; k >= 0; k--) q_m.push_back(ifm.in_data[k*8 +: 8]);
                for (int k = 0; k < 4; k++)  q_l.push_back(ifm.in_data[k*8 +: 8]);
                idx++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("rand_words_popped", 32'(idx), 32'd1000);
        chk("rand_segs_received", 32'(recv), 32'd4000);
        ifm.in_empty = 1'b1;
        ifm.out_full = 1'b0;
        @(negedge clk);
        chk_idle("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
